tblink_rpc_ep_mc: RTL and testbench

TBLINK_RPC_EP_MC -- requirements
Module: tblink_rpc_ep_mc

---
 rtl/tblink_rpc_ep_mc.sv | 222 ++++++++++++++++++++++
 tb/tb_tblink_rpc_ep_mc.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tblink_rpc_ep_mc.sv
// tblink_rpc_ep_mc -- multi-channel ring endpoint for the tblink RPC network.
//
// Packets are framed as DST, LEN, then LEN payload bytes. Ingress bytes addressed
// to a local channel (ADDR..ADDR+NCH-1) go to that channel's tipo lane. All
// other ingress packets are forwarded to the egress port. Egress is shared by
// the forward path (requester 0) and the local tipi sources (requester c+1).
// It is arbitrated round-robin one whole packet at a time. Once a path has been
// chosen, data moves combinationally, so each path carries one byte per cycle.
//
// Ports
//   uclock, reset                 clock (rising edge), asynchronous active-low reset
//   neti_dat/valid/ready          network ingress byte stream
//   neto_dat/valid/ready          network egress byte stream
//   tipo_dat/valid/ready          delivery to local channels, byte lane c = channel c
//   tipi_dat/valid/ready          local packet sources, byte lane c = channel c
module tblink_rpc_ep_mc #(
   parameter int ADDR = 1,
   parameter int NCH  = 2
) (
   input  logic               uclock,
   input  logic               reset,
   input  logic [7:0]         neti_dat,
   input  logic               neti_valid,
   output logic               neti_ready,
   output logic [7:0]         neto_dat,
   output logic               neto_valid,
   input  logic               neto_ready,
   output logic [NCH*8-1:0]   tipo_dat,
   output logic [NCH-1:0]     tipo_valid,
   input  logic [NCH-1:0]     tipo_ready,
   input  logic [NCH*8-1:0]   tipi_dat,
   input  logic [NCH-1:0]     tipi_valid,
   output logic [NCH-1:0]     tipi_ready
);

   localparam int IW = $clog2(NCH + 1);
   localparam int LW = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {I_DST, I_ROUTE, I_LEN, I_PAY} ist_t;
   typedef enum logic [1:0] {E_IDLE, E_DST, E_LEN, E_PAY} est_t;

   logic [NCH-1:0][7:0] tipi_b;
   assign tipi_b = tipi_dat;

   // ---------------- ingress ----------------
   ist_t            ist, ist_nxt;
   logic [7:0]      dst_r, icnt;
   logic            is_loc;
   logic [LW-1:0]   lane_r;
   logic            dst_loc;
   logic [LW-1:0]   dst_lane;
   logic            neti_xfer;
   logic            fwd_req, fwd_valid, fwd_ready;
   logic [7:0]      fwd_dat;
   logic            lo_valid;
   logic [7:0]      lo_dat;

   // Decode the incoming DST byte. The result is registered together with the
   // byte, so the route decision stays fixed for the rest of the packet.
   always_comb begin
      dst_loc  = (int'(neti_dat) >= ADDR) && (int'(neti_dat) < ADDR + NCH);
      dst_lane = LW'(int'(neti_dat) - ADDR);
   end

   assign neti_xfer = neti_valid && neti_ready;

   always_ff @(posedge uclock or negedge reset) begin
      if (!reset) begin
         ist    <= I_DST;
         dst_r  <= '0;
         icnt   <= '0;
         is_loc <= 1'b0;
         lane_r <= '0;
      end else begin
         ist <= ist_nxt;
         if (ist == I_DST && neti_xfer) begin
            dst_r  <= neti_dat;
            is_loc <= dst_loc;
            lane_r <= dst_lane;
         end
         if (ist == I_LEN && neti_xfer)
            icnt <= neti_dat;
         else if (ist == I_PAY && neti_xfer)
            icnt <= icnt - 8'd1;
      end
   end

   always_comb begin
      ist_nxt    = ist;
      neti_ready = 1'b0;
      fwd_req    = 1'b0;
      fwd_valid  = 1'b0;
      fwd_dat    = '0;
      lo_valid   = 1'b0;
      lo_dat     = '0;
      case (ist)
         I_DST: begin
            // Gating with reset keeps ready low while reset is held, and lets
            // it rise as soon as reset is released.
            neti_ready = reset;
            if (neti_valid && reset) ist_nxt = I_ROUTE;
         end
         I_ROUTE: begin
            // The captured DST is replayed toward the chosen target while
            // neti is held off.
            if (is_loc) begin
               lo_valid = 1'b1;
               lo_dat   = dst_r;
               if (tipo_ready[lane_r]) ist_nxt = I_LEN;
            end else begin
               fwd_req   = 1'b1;
               fwd_valid = 1'b1;
               fwd_dat   = dst_r;
               if (fwd_ready) ist_nxt = I_LEN;
            end
         end
         I_LEN, I_PAY: begin
            neti_ready = is_loc ? tipo_ready[lane_r] : fwd_ready;
            if (is_loc) begin
               lo_valid = neti_valid;
               lo_dat   = neti_dat;
            end else begin
               fwd_valid = neti_valid;
               fwd_dat   = neti_dat;
            end
            if (neti_xfer) begin
               if (ist == I_LEN)
                  ist_nxt = (neti_dat == 8'd0) ? I_DST : I_PAY;
               else if (icnt == 8'd1)
                  ist_nxt = I_DST;
            end
         end
      endcase
   end

   // ---------------- egress ----------------
   est_t            est, est_nxt;
   logic [IW-1:0]   gnt;        // current grant, and also the round-robin pointer
   logic [7:0]      ecnt;
   logic [NCH:0]    req;
   logic            arb_hit;
   logic [IW-1:0]   arb_idx;
   logic            src_valid;
   logic [7:0]      src_dat;
   logic            neto_xfer;
   logic            e_busy;

   assign req[0] = fwd_req;
   assign e_busy = (est != E_IDLE);

   // Search starts at the index just after the last grant.
   always_comb begin
      int k;
      k       = 0;
      arb_hit = 1'b0;
      arb_idx = '0;
      for (int i = 1; i <= NCH + 1; i++) begin
         k = (int'(gnt) + i) % (NCH + 1);
         if (!arb_hit && req[k]) begin
            arb_hit = 1'b1;
            arb_idx = IW'(k);
         end
      end
   end

   always_comb begin
      src_valid = 1'b0;
      src_dat   = '0;
      if (gnt == '0) begin
         src_valid = fwd_valid;
         src_dat   = fwd_dat;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (int'(gnt) == c + 1) begin
               src_valid = tipi_valid[c];
               src_dat   = tipi_b[c];
            end
         end
      end
   end

   assign neto_valid = e_busy && src_valid;
   assign neto_dat   = neto_valid ? src_dat : 8'h00;
   assign neto_xfer  = neto_valid && neto_ready;
   assign fwd_ready  = e_busy && (gnt == '0) && neto_ready;

   always_ff @(posedge uclock or negedge reset) begin
      if (!reset) begin
         est  <= E_IDLE;
         gnt  <= '0;
         ecnt <= '0;
      end else begin
         est <= est_nxt;
         if (est == E_IDLE && arb_hit) gnt <= arb_idx;
         if (est == E_LEN && neto_xfer)
            ecnt <= neto_dat;
         else if (est == E_PAY && neto_xfer)
            ecnt <= ecnt - 8'd1;
      end
   end

   // Egress parses the packet's own LEN byte, so the grant is released
   // exactly at the packet boundary.
   always_comb begin
      est_nxt = est;
      case (est)
         E_IDLE: if (arb_hit) est_nxt = E_DST;
         E_DST:  if (neto_xfer) est_nxt = E_LEN;
         E_LEN:  if (neto_xfer) est_nxt = (neto_dat == 8'd0) ? E_IDLE : E_PAY;
         E_PAY:  if (neto_xfer && ecnt == 8'd1) est_nxt = E_IDLE;
      endcase
   end

   // ---------------- per-channel lanes ----------------
   for (genvar c = 0; c < NCH; c++) begin : g_lane
      assign tipo_valid[c]       = lo_valid && (int'(lane_r) == c);
      assign tipo_dat[c*8 +: 8]  = tipo_valid[c] ? lo_dat : 8'h00;
      assign tipi_ready[c]       = e_busy && (int'(gnt) == c + 1) && neto_ready;
      assign req[c+1]            = tipi_valid[c];
   end

endmodule

// File: tb/tb_tblink_rpc_ep_mc.sv
// Scoreboard bench for tblink_rpc_ep_mc with ADDR=4 and NCH=2.
// Expected bytes are queued when a packet is driven. Monitors pop and compare
// them at the negative edge, on every transfer seen on neto or a tipo lane.
module tb_tblink_rpc_ep_mc;
   localparam int ADDR = 4;
   localparam int NCH  = 2;
   localparam int TMO  = 200;

   logic          uclock = 1'b0;
   logic          reset  = 1'b0;
   logic [7:0]    neti_dat;
   logic          neti_valid;
   logic          neti_ready;
   logic [7:0]    neto_dat;
   logic          neto_valid;
   logic          neto_ready;
   logic [15:0]   tipo_dat;
   logic [1:0]    tipo_valid;
   logic [1:0]    tipo_ready;
   logic [15:0]   tipi_dat;
   logic [1:0]    tipi_valid;
   logic [1:0]    tipi_ready;

   logic [7:0]    tdat [2];
   logic          tvld [2];
   assign tipi_dat   = {tdat[1], tdat[0]};
   assign tipi_valid = {tvld[1], tvld[0]};

   always #5 uclock = ~uclock;

   tblink_rpc_ep_mc #(.ADDR(ADDR), .NCH(NCH)) dut (
      .uclock(uclock), .reset(reset),
      .neti_dat(neti_dat), .neti_valid(neti_valid), .neti_ready(neti_ready),
      .neto_dat(neto_dat), .neto_valid(neto_valid), .neto_ready(neto_ready),
      .tipo_dat(tipo_dat), .tipo_valid(tipo_valid), .tipo_ready(tipo_ready),
      .tipi_dat(tipi_dat), .tipi_valid(tipi_valid), .tipi_ready(tipi_ready)
   );

   int errs   = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   logic [7:0] q_neto [$];
   logic [7:0] q_tipo [2][$];

   // monitors
   always @(negedge uclock) begin
      if (reset) begin
         if (neto_valid && neto_ready) begin
            if (q_neto.size() == 0) chk("neto_spurious", 32'(neto_valid), 32'd0);
            else chk("neto_dat", 32'(neto_dat), 32'(q_neto.pop_front()));
         end
         for (int l = 0; l < 2; l++) begin
            if (tipo_valid[l] && tipo_ready[l]) begin
               if (q_tipo[l].size() == 0)
                  chk($sformatf("tipo%0d_spurious", l), 32'(tipo_valid[l]), 32'd0);
               else
                  chk($sformatf("tipo%0d_dat", l), 32'(tipo_dat[l*8 +: 8]), 32'(q_tipo[l].pop_front()));
            end
         end
      end
   end

   // tgt: 0/1 = tipo lane, 2 = neto
   task automatic expect_pkt(input logic [7:0] p [$], input int tgt);
      foreach (p[i]) begin
         if (tgt == 2) q_neto.push_back(p[i]);
         else q_tipo[tgt].push_back(p[i]);
      end
   endtask

   task automatic neti_byte(input logic [7:0] b);
      int n;
      n = 0;
      neti_dat   = b;
      neti_valid = 1'b1;
      @(negedge uclock);
      while (!neti_ready && n < TMO) begin
         @(negedge uclock);
         n++;
      end
      if (!neti_ready) chk("neti_timeout", 32'(neti_ready), 32'd1);
      @(posedge uclock); #1;
      neti_valid = 1'b0;
      neti_dat   = 8'h00;
   endtask

   task automatic neti_pkt(input logic [7:0] p [$]);
      foreach (p[i]) neti_byte(p[i]);
   endtask

   task automatic tipi_byte(input int lane, input logic [7:0] b);
      int n;
      n = 0;
      tdat[lane] = b;
      tvld[lane] = 1'b1;
      @(negedge uclock);
      while (!tipi_ready[lane] && n < TMO) begin
         @(negedge uclock);
         n++;
      end
      if (!tipi_ready[lane]) chk($sformatf("tipi%0d_timeout", lane), 32'(tipi_ready[lane]), 32'd1);
      @(posedge uclock); #1;
      tvld[lane] = 1'b0;
      tdat[lane] = 8'h00;
   endtask

   task automatic tipi_pkt(input int lane, input logic [7:0] p [$]);
      foreach (p[i]) tipi_byte(lane, p[i]);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q_neto.size() + q_tipo[0].size() + q_tipo[1].size()) != 0 && n < TMO) begin
         @(posedge uclock);
         n++;
      end
      chk("drain_left", 32'(q_neto.size() + q_tipo[0].size() + q_tipo[1].size()), 32'd0);
      @(posedge uclock); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   bit         tog_on;
   int         rr_last;
   logic [7:0] pk [$];
   logic [7:0] pk2 [$];
   logic [7:0] ap [3][$];
   int         idx;

   initial begin
      neti_valid = 1'b0; neti_dat = 8'h00;
      neto_ready = 1'b1; tipo_ready = 2'b11;
      tvld[0] = 1'b0; tvld[1] = 1'b0; tdat[0] = 8'h00; tdat[1] = 8'h00;
      tog_on  = 1'b0;
      rr_last = 0;   // round-robin pointer resets to the forward index

      // ---- reset state, with stimulus pending on the inputs ----
      neti_valid = 1'b1; neti_dat = 8'h05;
      tvld[0] = 1'b1; tdat[0] = 8'h08;
      repeat (3) @(posedge uclock);
      #1;
      chk("rst_neti_ready", 32'(neti_ready), 32'd0);
      chk("rst_neto_valid", 32'(neto_valid), 32'd0);
      chk("rst_tipo_valid", 32'(tipo_valid), 32'd0);
      chk("rst_tipi_ready", 32'(tipi_ready), 32'd0);
      chk("rst_neto_dat", 32'(neto_dat), 32'd0);
      chk("rst_tipo_dat", 32'(tipo_dat), 32'd0);
      neti_valid = 1'b0; neti_dat = 8'h00;
      tvld[0] = 1'b0; tdat[0] = 8'h00;
      @(posedge uclock); #1;
      reset = 1'b1;
      #1;
      chk("rel_neti_ready", 32'(neti_ready), 32'd1);
      @(posedge uclock); #1;

      // ---- local delivery to lane 1 ----
      pk = {8'h05, 8'h02, 8'hAA, 8'hBB};
      expect_pkt(pk, 1);
      neti_pkt(pk);
      drain();

      // ---- forwarding with neto_ready toggling ----
      pk = {8'h09, 8'h01, 8'h3C};
      expect_pkt(pk, 2);
      tog_on = 1'b1;
      fork
         forever begin
            @(posedge uclock); #2;
            if (!tog_on) break;
            neto_ready = ~neto_ready;
         end
      join_none
      neti_pkt(pk);
      drain();
      tog_on = 1'b0;
      @(posedge uclock); #3;
      neto_ready = 1'b1;
      rr_last = 0;
      @(posedge uclock); #1;

      // ---- zero-length packet, then a 1-byte packet, both to lane 0 ----
      pk  = {8'h04, 8'h00};
      pk2 = {8'h04, 8'h01, 8'h77};
      expect_pkt(pk, 0);
      expect_pkt(pk2, 0);
      neti_pkt(pk);
      // Back in I_DST, ready must not follow the lane's ready.
      tipo_ready[0] = 1'b0;
      #1;
      chk("zl_back_to_dst", 32'(neti_ready), 32'd1);
      tipo_ready[0] = 1'b1;
      neti_pkt(pk2);
      drain();

      // ---- arbitration: forward, tipi0, tipi1 all at once ----
      ap[0] = {8'h0A, 8'h01, 8'hC1};
      ap[1] = {8'h20, 8'h01, 8'hD0};
      ap[2] = {8'h05, 8'h01, 8'hE0};   // local DST still goes out on neto
      for (int k = 1; k <= 3; k++) begin
         idx = (rr_last + k) % 3;
         expect_pkt(ap[idx], 2);
      end
      rr_last = idx;
      fork
         neti_pkt(ap[0]);
         tipi_pkt(0, ap[1]);
         tipi_pkt(1, ap[2]);
      join
      drain();

      // ---- backpressure on lane 0 while egress keeps moving ----
      pk  = {8'h04, 8'h03, 8'h11, 8'h22, 8'h33};
      pk2 = {8'h07, 8'h02, 8'h55, 8'h66};
      expect_pkt(pk, 0);
      expect_pkt(pk2, 2);
      rr_last = 2;
      neti_byte(8'h04);
      neti_byte(8'h03);
      tipo_ready[0] = 1'b0;
      neti_dat = 8'h11; neti_valid = 1'b1;
      fork
         tipi_pkt(1, pk2);
      join_none
      for (int c = 0; c < 10; c++) begin
         @(negedge uclock);
         chk($sformatf("bp_neti_ready_c%0d", c), 32'(neti_ready), 32'd0);
      end
      chk("bp_egress_done", 32'(q_neto.size()), 32'd0);
      @(posedge uclock); #1;
      tipo_ready[0] = 1'b1;
      neti_byte(8'h11);
      neti_byte(8'h22);
      neti_byte(8'h33);
      drain();

      // ---- reset in the middle of a forwarded packet ----
      pk = {8'h06, 8'h04, 8'h01};
      expect_pkt(pk, 2);
      neti_pkt(pk);
      neti_valid = 1'b1; neti_dat = 8'h02;
      reset = 1'b0;
      #1;
      chk("mid_rst_neto_valid", 32'(neto_valid), 32'd0);
      chk("mid_rst_tipo_valid", 32'(tipo_valid), 32'd0);
      chk("mid_rst_neti_ready", 32'(neti_ready), 32'd0);
      chk("mid_rst_tipi_ready", 32'(tipi_ready), 32'd0);
      chk("mid_rst_neto_q", 32'(q_neto.size()), 32'd0);
      neti_valid = 1'b0; neti_dat = 8'h00;
      repeat (2) @(posedge uclock);
      #1;
      reset = 1'b1;
      rr_last = 0;
      #1;
      chk("mid_rel_neti_ready", 32'(neti_ready), 32'd1);
      pk = {8'h05, 8'h00};
      expect_pkt(pk, 1);
      neti_pkt(pk);
      drain();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
